// File: rtl/v850_ddr_mem_bridge.sv
// V850 memory-stage to DDR3 application-interface bridge.
// Turns single byte/half/word loads and stores into one-line DDR3 app
// transactions, with an optional write-through one-line read buffer,
// alignment checking and a handshake timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_CALIB | DDR not calibrated, no requests accepted
// IDLE       | ready for a request
// RD_CMD     | read command presented, waiting for ddr_cmd_rdy_i
// RD_DATA    | waiting for the single read beat
// WR_CMD     | write command presented, waiting for ddr_cmd_rdy_i
// WR_DATA    | write beat presented, waiting for ddr_wr_rdy_i
// RESP       | one-cycle response pulse
module v850_ddr_mem_bridge #(
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int APP_ADDR_WIDTH = 29,
  parameter int DQ_WIDTH       = 32,
  parameter int APP_DATA_WIDTH = 256,
  parameter int LINE_BUF_EN    = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        calib_done_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [1:0]                  req_size_i,
  input  logic                        req_signed_i,
  input  logic [CPU_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [31:0]                 req_wdata_i,
  output logic                        resp_valid_o,
  output logic [31:0]                 resp_rdata_o,
  output logic                        resp_err_o,
  output logic [2:0]                  ddr_cmd_o,
  output logic                        ddr_cmd_en_o,
  input  logic                        ddr_cmd_rdy_i,
  output logic [APP_ADDR_WIDTH-1:0]   ddr_addr_o,
  output logic [APP_DATA_WIDTH-1:0]   ddr_wr_data_o,
  output logic                        ddr_wr_en_o,
  output logic                        ddr_wr_end_o,
  output logic [APP_DATA_WIDTH/8-1:0] ddr_wr_mask_o,
  input  logic                        ddr_wr_rdy_i,
  input  logic [APP_DATA_WIDTH-1:0]   ddr_rd_data_i,
  input  logic                        ddr_rd_valid_i,
  input  logic                        ddr_rd_end_i,
  output logic                        ddr_burst_o
);

  localparam int LINE_BYTES = APP_DATA_WIDTH / 8;
  localparam int LANE_W     = $clog2(LINE_BYTES);
  localparam int TAG_W      = CPU_ADDR_WIDTH - LANE_W;
  localparam int DQ_SHIFT   = $clog2(DQ_WIDTH / 8);
  localparam int BEAT_BITS  = $clog2(APP_DATA_WIDTH / DQ_WIDTH);
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_CALIB, IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, RESP
  } state_t;

  state_t state_q, state_next;

  logic [TMR_W-1:0]          tmr_q;
  logic                      timeout;
  logic                      waiting;
  logic                      rd_beat;

  logic [LANE_W-1:0]         req_lane;
  logic [TAG_W-1:0]          req_tag;
  logic                      req_bad;
  logic                      req_hit;
  logic [3:0]                req_be;
  logic [APP_ADDR_WIDTH-1:0] req_app_addr;
  logic [APP_DATA_WIDTH-1:0] req_line;
  logic [LINE_BYTES-1:0]     req_mask;

  logic [LANE_W-1:0]         lane_q;
  logic [TAG_W-1:0]          tag_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic                      err_q;
  logic [31:0]               rdata_q;
  logic [APP_ADDR_WIDTH-1:0] addr_q;
  logic [APP_DATA_WIDTH-1:0] wdata_q;
  logic [LINE_BYTES-1:0]     mask_q;

  logic                      buf_valid;
  logic [TAG_W-1:0]          buf_tag;
  logic [APP_DATA_WIDTH-1:0] buf_data;

  // Pull the addressed bytes out of a line and sign/zero-extend them.
  function automatic logic [31:0] extract(input logic [APP_DATA_WIDTH-1:0] line,
                                          input logic [LANE_W-1:0] lane,
                                          input logic [1:0] size,
                                          input logic sgn);
    logic [31:0] w;
    w = 32'(line >> {lane, 3'b000});
    case (size)
      2'd0:    extract = {{24{sgn & w[7]}}, w[7:0]};
      2'd1:    extract = {{16{sgn & w[15]}}, w[15:0]};
      default: extract = w;
    endcase
  endfunction

  assign req_lane     = req_addr_i[LANE_W-1:0];
  assign req_tag      = req_addr_i[CPU_ADDR_WIDTH-1:LANE_W];
  assign req_hit      = (LINE_BUF_EN != 0) && buf_valid && (buf_tag == req_tag);
  assign req_app_addr = APP_ADDR_WIDTH'((req_addr_i >> DQ_SHIFT) &
                        ~(CPU_ADDR_WIDTH'((1 << BEAT_BITS) - 1)));
  assign rd_beat      = ddr_rd_valid_i & ddr_rd_end_i;
  assign waiting      = (state_q == RD_CMD) || (state_q == RD_DATA) ||
                        (state_q == WR_CMD) || (state_q == WR_DATA);
  assign ddr_burst_o  = 1'b1;
  assign ddr_addr_o   = addr_q;
  assign ddr_wr_data_o = wdata_q;
  assign ddr_wr_mask_o = mask_q;

  // Request decode: alignment check, byte enables and lane placement of store data.
  always_comb begin
    req_bad = 1'b0;
    req_be  = 4'b1111;
    case (req_size_i)
      2'd0: begin req_bad = 1'b0;             req_be = 4'b0001; end
      2'd1: begin req_bad = req_addr_i[0];    req_be = 4'b0011; end
      2'd2: begin req_bad = |req_addr_i[1:0]; req_be = 4'b1111; end
      default: begin req_bad = 1'b1;          req_be = 4'b0000; end
    endcase
    req_line = APP_DATA_WIDTH'(req_wdata_i & {{8{req_be[3]}}, {8{req_be[2]}},
                                              {8{req_be[1]}}, {8{req_be[0]}}})
               << {req_lane, 3'b000};
    req_mask = ~(LINE_BYTES'(req_be) << req_lane);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_CALIB;
    else        state_q <= state_next;
  end

  // Next state and handshake outputs; timeout wins only when no handshake completes.
  always_comb begin
    state_next    = state_q;
    timeout       = 1'b0;
    req_ready_o   = 1'b0;
    ddr_cmd_o     = 3'b000;
    ddr_cmd_en_o  = 1'b0;
    ddr_wr_en_o   = 1'b0;
    ddr_wr_end_o  = 1'b0;
    resp_valid_o  = 1'b0;
    resp_err_o    = 1'b0;
    resp_rdata_o  = '0;
    case (state_q)
      WAIT_CALIB: if (calib_done_i) state_next = IDLE;
      IDLE: begin
        req_ready_o = calib_done_i;
        if (!calib_done_i)                 state_next = WAIT_CALIB;
        else if (req_valid_i) begin
          if (req_bad)                     state_next = RESP;
          else if (req_write_i)            state_next = WR_CMD;
          else if (req_hit)                state_next = RESP;
          else                             state_next = RD_CMD;
        end
      end
      RD_CMD: begin
        ddr_cmd_o    = 3'b001;
        ddr_cmd_en_o = 1'b1;
        if (ddr_cmd_rdy_i)       state_next = RD_DATA;
        else if (tmr_q == '0) begin timeout = 1'b1; state_next = RESP; end
      end
      RD_DATA: begin
        if (rd_beat)             state_next = RESP;
        else if (tmr_q == '0) begin timeout = 1'b1; state_next = RESP; end
      end
      WR_CMD: begin
        ddr_cmd_en_o = 1'b1;
        if (ddr_cmd_rdy_i)       state_next = WR_DATA;
        else if (tmr_q == '0) begin timeout = 1'b1; state_next = RESP; end
      end
      WR_DATA: begin
        ddr_wr_en_o  = 1'b1;
        ddr_wr_end_o = 1'b1;
        if (ddr_wr_rdy_i)        state_next = RESP;
        else if (tmr_q == '0) begin timeout = 1'b1; state_next = RESP; end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        resp_rdata_o = rdata_q;
        state_next   = calib_done_i ? IDLE : WAIT_CALIB;
      end
      default: state_next = WAIT_CALIB;
    endcase
  end

  // Handshake timer: reloads on every state change, counts down while waiting on DDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      tmr_q <= TMR_LOAD;
    else if (state_next != state_q)  tmr_q <= TMR_LOAD;
    else if (waiting && tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
  end

  // Request latch and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= '0;
      tag_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
    end else begin
      if (req_ready_o && req_valid_i) begin
        lane_q   <= req_lane;
        tag_q    <= req_tag;
        size_q   <= req_size_i;
        signed_q <= req_signed_i;
        err_q    <= req_bad;
        addr_q   <= req_app_addr;
        rdata_q  <= '0;
        if (req_write_i && !req_bad) begin
          wdata_q <= req_line;
          mask_q  <= req_mask;
        end
        if (!req_write_i && !req_bad && req_hit)
          rdata_q <= extract(buf_data, req_lane, req_size_i, req_signed_i);
      end
      if (state_q == RD_DATA && rd_beat)
        rdata_q <= extract(ddr_rd_data_i, lane_q, size_q, signed_q);
      if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  // One-line read buffer: filled by reads, kept coherent by write-through, dropped on read timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (LINE_BUF_EN != 0) begin
      if (state_q == RD_DATA && rd_beat) begin
        buf_data  <= ddr_rd_data_i;
        buf_tag   <= tag_q;
        buf_valid <= 1'b1;
      end else if (timeout && (state_q == RD_CMD || state_q == RD_DATA)) begin
        buf_valid <= 1'b0;
      end else if (state_q == WR_DATA && ddr_wr_rdy_i && buf_valid && buf_tag == tag_q) begin
        for (int i = 0; i < LINE_BYTES; i++)
          if (!mask_q[i]) buf_data[i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_v850_ddr_mem_bridge.sv
// Directed bench for v850_ddr_mem_bridge with a small DDR responder.
module tb_v850_ddr_mem_bridge;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         calib_done_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_write_i;
  logic [1:0]   req_size_i;
  logic         req_signed_i;
  logic [31:0]  req_addr_i;
  logic [31:0]  req_wdata_i;
  logic         resp_valid_o;
  logic [31:0]  resp_rdata_o;
  logic         resp_err_o;
  logic [2:0]   ddr_cmd_o;
  logic         ddr_cmd_en_o;
  logic         ddr_cmd_rdy_i;
  logic [28:0]  ddr_addr_o;
  logic [255:0] ddr_wr_data_o;
  logic         ddr_wr_en_o;
  logic         ddr_wr_end_o;
  logic [31:0]  ddr_wr_mask_o;
  logic         ddr_wr_rdy_i;
  logic [255:0] ddr_rd_data_i;
  logic         ddr_rd_valid_i;
  logic         ddr_rd_end_i;
  logic         ddr_burst_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] rd_line;
  int           rd_phase = 0;
  int           cmd_cnt = 0;
  int           wr_cnt = 0;
  int           resp_cnt = 0;
  logic [2:0]   last_cmd = 3'b111;
  logic [28:0]  last_addr = '0;
  logic [255:0] last_wdata = '0;
  logic [31:0]  last_mask = '0;
  logic         last_wr_end = 1'b0;
  logic         cmd_en_seen = 1'b0;
  logic         ready_seen = 1'b0;

  v850_ddr_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done_i(calib_done_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .ddr_cmd_o(ddr_cmd_o), .ddr_cmd_en_o(ddr_cmd_en_o),
    .ddr_cmd_rdy_i(ddr_cmd_rdy_i), .ddr_addr_o(ddr_addr_o), .ddr_wr_data_o(ddr_wr_data_o),
    .ddr_wr_en_o(ddr_wr_en_o), .ddr_wr_end_o(ddr_wr_end_o), .ddr_wr_mask_o(ddr_wr_mask_o),
    .ddr_wr_rdy_i(ddr_wr_rdy_i), .ddr_rd_data_i(ddr_rd_data_i), .ddr_rd_valid_i(ddr_rd_valid_i),
    .ddr_rd_end_i(ddr_rd_end_i), .ddr_burst_o(ddr_burst_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // DDR responder and bus monitor; everything is observed on the falling edge.
  initial begin
    ddr_rd_valid_i = 1'b0;
    ddr_rd_end_i   = 1'b0;
    ddr_rd_data_i  = '0;
    forever begin
      @(negedge clk);
      if (rd_phase == 2) begin
        ddr_rd_valid_i = 1'b0;
        ddr_rd_end_i   = 1'b0;
        rd_phase       = 0;
      end else if (rd_phase == 1) begin
        ddr_rd_valid_i = 1'b1;
        ddr_rd_end_i   = 1'b1;
        ddr_rd_data_i  = rd_line;
        rd_phase       = 2;
      end
      if (ddr_cmd_en_o) cmd_en_seen = 1'b1;
      if (req_ready_o)  ready_seen  = 1'b1;
      if (ddr_cmd_en_o && ddr_cmd_rdy_i) begin
        cmd_cnt++;
        last_cmd  = ddr_cmd_o;
        last_addr = ddr_addr_o;
        if (ddr_cmd_o == 3'b001) rd_phase = 1;
      end
      if (ddr_wr_en_o && ddr_wr_rdy_i) begin
        wr_cnt++;
        last_wdata  = ddr_wr_data_o;
        last_mask   = ddr_wr_mask_o;
        last_wr_end = ddr_wr_end_o;
      end
      if (resp_valid_o) resp_cnt++;
    end
  end

  // One request: present, wait for acceptance, wait for the response pulse.
  // lat = 1 means the response is visible in the cycle right after acceptance.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic drop,
                       output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic got;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_write_i = w; req_size_i = sz; req_signed_i = sg;
    req_addr_i = a; req_wdata_i = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o && n < 50);
    if (!req_ready_o) check_val("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (drop) calib_done_i = 1'b0;
    lat = 0; got = 1'b0; rd = '0; er = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (resp_valid_o) begin got = 1'b1; rd = resp_rdata_o; er = resp_err_o; end
    end
    if (!got) check_val("resp_timeout", 0, 1);
    @(negedge clk);
    check_val("resp_one_cycle", resp_valid_o, 0);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          base;
    int          n;

    rst_n = 1'b0; calib_done_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0;
    req_size_i = '0; req_signed_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    ddr_cmd_rdy_i = 1'b0; ddr_wr_rdy_i = 1'b0;
    rd_line = {192'h0, 32'h80AB_CDEF, 32'h1122_3344};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready",  req_ready_o, 0);
    check_val("rst_resp",   resp_valid_o, 0);
    check_val("rst_cmd_en", ddr_cmd_en_o, 0);
    check_val("rst_wr_en",  ddr_wr_en_o, 0);
    check_val("rst_mask",   ddr_wr_mask_o, 0);
    check_val("rst_burst",  ddr_burst_o, 1);

    // calibration not done: never ready even with a request pending
    #1 rst_n = 1'b1;
    req_valid_i = 1'b1;
    ready_seen = 1'b0;
    repeat (6) @(negedge clk);
    #1 check_val("ready_no_calib", ready_seen, 0);
    req_valid_i = 1'b0;
    calib_done_i = 1'b1; ddr_cmd_rdy_i = 1'b1; ddr_wr_rdy_i = 1'b1;

    // store word 0xDEADBEEF to 0x24
    base = cmd_cnt;
    issue(1'b1, 2'd2, 1'b0, 32'h24, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    check_val("st_w_err",    er, 0);
    check_val("st_w_rdata",  rd, 0);
    check_val("st_w_lat",    lat, 3);
    check_val("st_w_ncmd",   cmd_cnt - base, 1);
    check_val("st_w_cmd",    last_cmd, 3'b000);
    check_val("st_w_addr",   last_addr, 29'h8);
    check_val("st_w_data",   last_wdata, 256'hDEAD_BEEF_0000_0000);
    check_val("st_w_mask",   last_mask, 32'hFFFF_FF0F);
    check_val("st_w_end",    last_wr_end, 1);

    // signed byte load miss from 0x27
    base = cmd_cnt;
    issue(1'b0, 2'd0, 1'b1, 32'h27, 32'h0, 1'b0, rd, er, lat);
    check_val("ld_sb_data", rd, 32'hFFFF_FF80);
    check_val("ld_sb_err",  er, 0);
    check_val("ld_sb_ncmd", cmd_cnt - base, 1);
    check_val("ld_sb_cmd",  last_cmd, 3'b001);
    check_val("ld_sb_addr", last_addr, 29'h8);
    check_val("ld_sb_lat",  lat, 3);

    // repeat unsigned load hits the buffer
    base = cmd_cnt;
    issue(1'b0, 2'd0, 1'b0, 32'h27, 32'h0, 1'b0, rd, er, lat);
    check_val("hit_ub_data", rd, 32'h0000_0080);
    check_val("hit_ub_ncmd", cmd_cnt - base, 0);
    check_val("hit_ub_lat",  lat, 1);
    issue(1'b0, 2'd1, 1'b1, 32'h24, 32'h0, 1'b0, rd, er, lat);
    check_val("hit_sh_data", rd, 32'hFFFF_CDEF);
    issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0, rd, er, lat);
    check_val("hit_w_data",  rd, 32'h80AB_CDEF);

    // half store into the buffered line, then read back from the buffer
    base = cmd_cnt;
    n = wr_cnt;
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD_1234, 1'b0, rd, er, lat);
    check_val("st_h_nwr",  wr_cnt - n, 1);
    check_val("st_h_mask", last_mask, 32'hFFFF_FFF3);
    check_val("st_h_data", last_wdata, 256'h1234_0000);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, rd, er, lat);
    check_val("wt_h_data", rd, 32'h0000_1234);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
    check_val("wt_w_data", rd, 32'h1234_3344);
    check_val("wt_ncmd",   cmd_cnt - base, 1);

    // early errors: misaligned word, reserved size, misaligned half store
    cmd_en_seen = 1'b0;
    n = wr_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0, rd, er, lat);
    check_val("mis_w_err",   er, 1);
    check_val("mis_w_rdata", rd, 0);
    check_val("mis_w_lat",   lat, 1);
    issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
    check_val("rsv_err",     er, 1);
    issue(1'b1, 2'd1, 1'b0, 32'h23, 32'h5555, 1'b0, rd, er, lat);
    check_val("mis_h_err",   er, 1);
    check_val("mis_no_cmd",  cmd_en_seen, 0);
    check_val("mis_no_wr",   wr_cnt - n, 0);

    // command timeout on a read
    ddr_cmd_rdy_i = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
    check_val("to_err",   er, 1);
    check_val("to_rdata", rd, 0);
    check_val("to_lat",   lat, TO + 1);
    check_val("to_idle",  req_ready_o, 1);
    ddr_cmd_rdy_i = 1'b1;
    base = cmd_cnt;
    issue(1'b0, 2'd0, 1'b0, 32'h27, 32'h0, 1'b0, rd, er, lat);
    check_val("to_inval_ncmd", cmd_cnt - base, 1);
    check_val("to_inval_data", rd, 32'h0000_0080);

    // calibration lost mid-store: store finishes, then back to WAIT_CALIB
    issue(1'b1, 2'd0, 1'b0, 32'h30, 32'h0000_005A, 1'b1, rd, er, lat);
    check_val("cal_st_err",  er, 0);
    check_val("cal_st_mask", last_mask, 32'hFFFE_FFFF);
    check_val("cal_st_data", last_wdata, 256'h5A << 128);
    calib_done_i = 1'b1;
    #1 check_val("cal_wait_state", req_ready_o, 0);
    @(negedge clk);
    check_val("cal_idle_again", req_ready_o, 1);
    base = cmd_cnt;
    issue(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
    check_val("cal_wt_data", rd, 32'h0000_005A);
    check_val("cal_wt_ncmd", cmd_cnt - base, 0);

    // asynchronous reset while in WR_DATA
    ddr_wr_rdy_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'd2;
    req_addr_i = 32'h28; req_wdata_i = 32'h0102_0304;
    n = 0;
    do begin @(negedge clk); n++; if (!req_ready_o) req_valid_i = 1'b0; end
      while (!ddr_wr_en_o && n < 20);
    check_val("rst_reach_wr", ddr_wr_en_o, 1);
    base = resp_cnt;
    #2 rst_n = 1'b0; req_valid_i = 1'b0;
    #1;
    check_val("arst_wr_en",   ddr_wr_en_o, 0);
    check_val("arst_wr_end",  ddr_wr_end_o, 0);
    check_val("arst_cmd_en",  ddr_cmd_en_o, 0);
    check_val("arst_mask",    ddr_wr_mask_o, 0);
    check_val("arst_wdata",   ddr_wr_data_o, 0);
    check_val("arst_addr",    ddr_addr_o, 0);
    check_val("arst_resp",    resp_valid_o, 0);
    check_val("arst_burst",   ddr_burst_o, 1);
    repeat (3) @(negedge clk);
    #1 check_val("arst_no_resp", resp_cnt - base, 0);
    rst_n = 1'b1;
    ddr_wr_rdy_i = 1'b1;
    base = cmd_cnt;
    issue(1'b0, 2'd0, 1'b1, 32'h27, 32'h0, 1'b0, rd, er, lat);
    check_val("arst_buf_inval", cmd_cnt - base, 1);
    check_val("arst_ld_data",   rd, 32'hFFFF_FF80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
